piso_serializer_8bit: RTL and testbench

- Downstream stage of the 8-bit 2:1 mux datapath. Captures the selected byte from the mux output and shifts it out one bit per accepted cycle.
- Provides a valid/ready handshake on both the parallel input and the serial output.
- Supports back-to-back bytes with no bubble cycle.

---
 rtl/piso_serializer_8bit_pkg.sv | 17 +
 rtl/piso_serializer_8bit_if.sv | 36 +++
 rtl/piso_serializer_8bit_counter_mod_n.sv | 39 +++
 rtl/piso_serializer_8bit.sv | 101 ++++++++++
 tb/tb_piso_serializer_8bit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_8bit_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encodings and the default word width.
`ifndef PISO_SERIALIZER_8BIT_PKG_SV
`define PISO_SERIALIZER_8BIT_PKG_SV

package piso_serializer_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

`endif

// File: rtl/piso_serializer_8bit_if.sv
// Parallel-load and serial-output handshake bundle of the serializer.
interface piso_serializer_8bit_if
    import piso_serializer_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Both sides use strict valid/ready: a transfer happens on a rising edge
    // where valid and ready are both high; valid must not depend on ready, and
    // the data must stay stable while valid is high and ready is low.
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        output sout_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        input  sout_ready
    );

endinterface

// File: rtl/piso_serializer_8bit_counter_mod_n.sv
// Modulo-N up counter with synchronous clear and a combinational last flag.
module counter_mod_n #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [$clog2(N)-1:0] count,
    output logic                 last
);

    localparam int                 CW     = $clog2(N);
    localparam logic [CW-1:0]      LAST_V = CW'(N - 1);

    logic [CW-1:0] count_q, count_d;

    // Clear wins over enable so a reload on the final count restarts at zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST_V) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_V);

endmodule

// File: rtl/piso_serializer_8bit.sv
// Parallel-in / serial-out serializer: loads a word from the mux datapath and
// shifts it out one bit per accepted cycle, with back-to-back reload.
module piso_serializer_8bit
    import piso_serializer_8bit_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    piso_serializer_8bit_if.slave    bus,
    output logic                     busy,
    output logic                     done,
    output state_e                   dbg_state,
    output logic [$clog2(WIDTH)-1:0] dbg_bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bit_cnt;
    logic             cnt_clr, cnt_en, cnt_last;
    logic             in_shift, din_ready_w, load, accept, out_bit;
    logic [WIDTH-1:0] shifted;

    assign in_shift    = (state_q == S_SHIFT);
    // On the last bit a new word may enter only if that bit leaves this cycle.
    assign din_ready_w = !in_shift || (cnt_last && bus.sout_ready);
    assign load        = bus.din_valid && din_ready_w;
    assign accept      = in_shift && bus.sout_ready;
    assign out_bit     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted     = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_q[WIDTH-1:1]};

    counter_mod_n #(
        .N (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bit_cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = bus.din;
                    cnt_clr = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    shift_d = shifted;
                    cnt_en  = 1'b1;
                    if (cnt_last) begin
                        done_d = 1'b1;
                        if (load) begin
                            shift_d = bus.din;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign bus.din_ready  = din_ready_w;
    assign bus.sout_valid = in_shift;
    assign bus.sout       = in_shift && out_bit;
    assign busy           = in_shift;
    assign done           = done_q;
    assign dbg_state      = state_q;
    assign dbg_bit_cnt    = bit_cnt;

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Directed bench for piso_serializer_8bit: MSB-first and LSB-first instances,
// bit-level scoreboard fed from hand-written expected streams.
module tb_piso_serializer_8bit;
    import piso_serializer_8bit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_serializer_8bit_if #(.WIDTH(8)) m_if ();
    piso_serializer_8bit_if #(.WIDTH(8)) l_if ();

    logic       m_busy, m_done, l_busy, l_done;
    state_e     m_state, l_state;
    logic [2:0] m_cnt, l_cnt;

    piso_serializer_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (m_if.slave),
        .busy        (m_busy),
        .done        (m_done),
        .dbg_state   (m_state),
        .dbg_bit_cnt (m_cnt)
    );

    piso_serializer_8bit #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (l_if.slave),
        .busy        (l_busy),
        .done        (l_done),
        .dbg_state   (l_state),
        .dbg_bit_cnt (l_cnt)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [0:0] exp_q[$];
    logic [7:0] words_q[$];
    int         acc_total, done_cnt, loads, mid_ready, gap_cnt, extra_bits;
    int         first_valid;
    bit         timed_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pushes an expected stream written in transmission order (first bit leftmost).
    task automatic push_exp(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    endtask

    // ---------------- driver + monitor for the MSB-first instance ----------------
    task automatic run(input bit toggle, input int tail_n, input int budget);
        int         cyc = 0;
        int         tail = 0;
        int         last_acc = -10;
        bit         started = 1'b0;
        bit         held = 1'b0;
        logic       held_bit = 1'b0;
        logic [0:0] e;
        acc_total = 0; done_cnt = 0; loads = 0; mid_ready = 0;
        gap_cnt = 0; extra_bits = 0; first_valid = -1; timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            m_if.sout_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (words_q.size() > 0) begin
                m_if.din       = words_q[0];
                m_if.din_valid = 1'b1;
            end else begin
                m_if.din_valid = 1'b0;
            end
            #1;
            if (m_done) begin
                done_cnt++;
                check_eq("done_after_last", {31'b0, (cyc == last_acc + 1) && (acc_total % 8 == 0)}, 32'd1);
            end
            if (held && m_if.sout_valid) check_eq("stall_hold", {31'b0, m_if.sout}, {31'b0, held_bit});
            held = 1'b0;
            if (m_if.sout_valid) begin
                if (!started) first_valid = cyc;
                started = 1'b1;
            end else if (started && (words_q.size() > 0 || exp_q.size() > 0)) begin
                gap_cnt++;
            end
            if (m_if.sout_valid && m_if.din_ready && (acc_total % 8) != 7) mid_ready++;
            if (m_if.din_valid && m_if.din_ready) begin
                void'(words_q.pop_front());
                loads++;
            end
            if (m_if.sout_valid && m_if.sout_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("bit%0d", acc_total), {31'b0, m_if.sout}, {31'b0, e});
                end else begin
                    extra_bits++;
                end
                acc_total++;
                last_acc = cyc;
            end else if (m_if.sout_valid) begin
                held     = 1'b1;
                held_bit = m_if.sout;
            end
            cyc++;
            if (words_q.size() == 0 && exp_q.size() == 0) begin
                if (tail >= tail_n) break;
                tail++;
            end
            if (cyc > budget) begin
                timed_out = 1'b1;
                exp_q.delete();
                words_q.delete();
                break;
            end
        end
        m_if.din_valid = 1'b0;
        check_eq("timeout", {31'b0, timed_out}, 32'd0);
        check_eq("extra_bits", extra_bits, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] lsb_pat;
    logic [7:0] inp1, inp2;

    initial begin
        m_if.din = '0; m_if.din_valid = 1'b0; m_if.sout_ready = 1'b0;
        l_if.din = '0; l_if.din_valid = 1'b0; l_if.sout_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_din_ready", {31'b0, m_if.din_ready}, 32'd1);
        check_eq("rst_sout_valid", {31'b0, m_if.sout_valid}, 32'd0);
        check_eq("rst_sout", {31'b0, m_if.sout}, 32'd0);
        check_eq("rst_busy", {31'b0, m_busy}, 32'd0);
        check_eq("rst_done", {31'b0, m_done}, 32'd0);
        check_eq("rst_state", {31'b0, m_state}, {31'b0, S_IDLE});
        check_eq("rst_bit_cnt", {29'b0, m_cnt}, 32'd0);
        rst_n = 1'b1;

        // Single word 0xA5, MSB first
        words_q.push_back(8'hA5);
        push_exp(8'b10100101);
        run(1'b0, 3, 40);
        check_eq("a5_first_latency", first_valid, 1);
        check_eq("a5_accepts", acc_total, 8);
        check_eq("a5_done_cnt", done_cnt, 1);
        check_eq("a5_busy_end", {31'b0, m_busy}, 32'd0);

        // LSB-first instance, 0x01
        lsb_pat = 8'b10000000;
        @(negedge clk);
        l_if.din = 8'h01; l_if.din_valid = 1'b1; l_if.sout_ready = 1'b1;
        #1;
        check_eq("lsb_load_ready", {31'b0, l_if.din_ready}, 32'd1);
        @(negedge clk);
        l_if.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq($sformatf("lsb_valid%0d", i), {31'b0, l_if.sout_valid}, 32'd1);
            check_eq($sformatf("lsb_bit%0d", i), {31'b0, l_if.sout}, {31'b0, lsb_pat[7-i]});
            @(negedge clk);
        end
        #1;
        check_eq("lsb_done", {31'b0, l_done}, 32'd1);
        check_eq("lsb_busy_end", {31'b0, l_busy}, 32'd0);

        // Backpressure, 0xC3 with ready toggling
        words_q.push_back(8'hC3);
        push_exp(8'b11000011);
        run(1'b1, 3, 60);
        check_eq("bp_accepts", acc_total, 8);
        check_eq("bp_done_cnt", done_cnt, 1);
        check_eq("bp_gap", gap_cnt, 0);

        // Back-to-back words 0xF0 then 0x0F
        words_q.push_back(8'hF0);
        words_q.push_back(8'h0F);
        push_exp(8'b11110000);
        push_exp(8'b00001111);
        run(1'b0, 3, 60);
        check_eq("b2b_accepts", acc_total, 16);
        check_eq("b2b_loads", loads, 2);
        check_eq("b2b_mid_ready", mid_ready, 0);
        check_eq("b2b_done_cnt", done_cnt, 2);
        check_eq("b2b_gap", gap_cnt, 0);
        check_eq("b2b_busy_end", {31'b0, m_busy}, 32'd0);

        // Reset mid-word: 0xFF, abort after 3 accepted bits
        words_q.push_back(8'hFF);
        push_exp(8'b11100000 >> 0 == 8'b11100000 ? 8'b11100000 : 8'b0);
        repeat (5) void'(exp_q.pop_back());
        run(1'b0, 0, 20);
        check_eq("mid_accepts", acc_total, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sout_valid", {31'b0, m_if.sout_valid}, 32'd0);
        check_eq("mid_rst_busy", {31'b0, m_busy}, 32'd0);
        check_eq("mid_rst_din_ready", {31'b0, m_if.din_ready}, 32'd1);
        check_eq("mid_rst_done", {31'b0, m_done}, 32'd0);
        @(negedge clk);
        check_eq("mid_rst_done_hold", {31'b0, m_done}, 32'd0);
        check_eq("mid_rst_bit_cnt", {29'b0, m_cnt}, 32'd0);
        rst_n = 1'b1;
        words_q.push_back(8'h80);
        push_exp(8'b10000000);
        run(1'b0, 3, 40);
        check_eq("post_rst_accepts", acc_total, 8);
        check_eq("post_rst_done_cnt", done_cnt, 1);

        // Mux integration: sel=0 picks inp1, sel=1 picks inp2
        inp1 = 8'h3C;
        inp2 = 8'h81;
        for (int sel = 0; sel < 2; sel++) begin
            words_q.push_back(sel == 1 ? inp2 : inp1);
        end
        push_exp(8'b00111100);
        push_exp(8'b10000001);
        run(1'b0, 3, 60);
        check_eq("mux_accepts", acc_total, 16);
        check_eq("mux_done_cnt", done_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
